// File: rtl/bits_pkg.sv
// Shared definitions for the bit packer: FSM state encoding and the
// helper that sizes fill/length fields from a word width.
package bits_pkg;

    typedef enum logic {
        ACCUMULATE    = 1'b0,
        FLUSH_PENDING = 1'b1
    } pack_state_t;

    // Width needed to hold a bit count from 0 up to word_width inclusive
    function automatic int fill_width(input int word_width);
        return $clog2(word_width) + 1;
    endfunction

endpackage

// File: rtl/bits_inserter.sv
// Combinational merge of one chunk into a partially filled word.
// "merged" is the word with the chunk placed at the given offset; "overflow"
// holds the chunk bits that spill past the word end, already aligned to where
// they sit in the next word (offset 0).
// Build option: BITS_PACKER_MSB_FIRST_EN selects MSB-first packing.
module bits_inserter
    import bits_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH  = 8,
    parameter int LENGTH_BIT_WIDTH = $clog2(INPUT_BIT_WIDTH) + 1,
    parameter int OUTPUT_BIT_WIDTH = 32,
    parameter int FILL_WIDTH       = fill_width(OUTPUT_BIT_WIDTH)
) (
    input  logic [OUTPUT_BIT_WIDTH-1:0] word,
    input  logic [INPUT_BIT_WIDTH-1:0]  chunk,
    input  logic [LENGTH_BIT_WIDTH-1:0] length,
    input  logic [FILL_WIDTH-1:0]       offset,
    output logic [OUTPUT_BIT_WIDTH-1:0] merged,
    output logic [OUTPUT_BIT_WIDTH-1:0] overflow
);

    localparam int IW = INPUT_BIT_WIDTH;
    localparam int OW = OUTPUT_BIT_WIDTH;
    localparam int WW = OW + IW;

    logic [IW-1:0] chunk_clean;
    logic [WW-1:0] wide;

    // Drop chunk bits at or above length, then splice the chunk into a
    // word-plus-chunk wide vector so the spill-over falls out for free
    always_comb begin
        chunk_clean = chunk & ~({IW{1'b1}} << length);
        wide        = '0;
        merged      = '0;
        overflow    = '0;
`ifdef BITS_PACKER_MSB_FIRST_EN
        // Word sits in the top OW bits; chunk bit length-1 lands just below
        // the bits already filled, so the chunk's low end starts at
        // WW - offset - length.
        wide     = {word, {IW{1'b0}}}
                 | ({{OW{1'b0}}, chunk_clean} << (WW - int'(offset) - int'(length)));
        merged   = wide[WW-1:IW];
        overflow = OW'(wide[IW-1:0]) << (OW - IW);
`else
        wide     = {{IW{1'b0}}, word} | ({{OW{1'b0}}, chunk_clean} << offset);
        merged   = wide[OW-1:0];
        overflow = OW'(wide[WW-1:OW]);
`endif
    end

endmodule

// File: rtl/bits_packer.sv
// Packs variable-length bit chunks into fixed-width output words, with
// optional flush of a partial word padded by FILL_BIT.
// Build option: BITS_PACKER_MSB_FIRST_EN packs MSB-first with partial words
// left-aligned; otherwise packing is LSB-first.
//
// state         | meaning
// ------------- | --------------------------------------------------------
// ACCUMULATE    | accepting chunks into the accumulator
// FLUSH_PENDING | full word emitted by a flush; residue waits for the
//               | output register to free before going out as partial word
module bits_packer
    import bits_pkg::*;
#(
    parameter int   INPUT_BIT_WIDTH  = 8,
    parameter int   LENGTH_BIT_WIDTH = $clog2(INPUT_BIT_WIDTH) + 1,
    parameter int   OUTPUT_BIT_WIDTH = 32,
    parameter logic FILL_BIT         = 1'b0
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    input_valid,
    output logic                                    input_ready,
    input  logic [INPUT_BIT_WIDTH-1:0]              input_bits,
    input  logic [LENGTH_BIT_WIDTH-1:0]             input_length,
    input  logic                                    input_flush,
    output logic                                    output_valid,
    input  logic                                    output_ready,
    output logic [OUTPUT_BIT_WIDTH-1:0]             output_bits,
    output logic [fill_width(OUTPUT_BIT_WIDTH)-1:0] output_length
);

    localparam int IW = INPUT_BIT_WIDTH;
    localparam int LW = LENGTH_BIT_WIDTH;
    localparam int OW = OUTPUT_BIT_WIDTH;
    localparam int FW = fill_width(OUTPUT_BIT_WIDTH);
    localparam int SW = FW + 1;

    pack_state_t   state_q, state_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [OW-1:0] out_bits_q, out_bits_d;
    logic [FW-1:0] out_len_q, out_len_d;
    logic          out_valid_q, out_valid_d;
    logic          ready_en_q;

    logic [LW-1:0] len_c;
    logic [SW-1:0] sum;
    logic          complete;
    logic [FW-1:0] new_fill;
    logic          out_free;
    logic          accepted;
    logic [OW-1:0] merged;
    logic [OW-1:0] overflow;

    // Keep the f valid bits of a partial word and pad the rest with FILL_BIT
    function automatic logic [OW-1:0] partial_word(input logic [OW-1:0] w,
                                                   input logic [FW-1:0] f);
        logic [OW-1:0] keep;
`ifdef BITS_PACKER_MSB_FIRST_EN
        keep = ~({OW{1'b1}} >> f);
`else
        keep = ~({OW{1'b1}} << f);
`endif
        return FILL_BIT ? (w | ~keep) : (w & keep);
    endfunction

    // Clamp the chunk length and work out where it leaves the fill pointer
    always_comb begin
        len_c    = (input_length > LW'(IW)) ? LW'(IW) : input_length;
        sum      = SW'(fill_q) + SW'(len_c);
        complete = (sum >= SW'(OW));
        new_fill = complete ? FW'(sum - SW'(OW)) : FW'(sum);
    end

    bits_inserter #(
        .INPUT_BIT_WIDTH (IW),
        .LENGTH_BIT_WIDTH(LW),
        .OUTPUT_BIT_WIDTH(OW),
        .FILL_WIDTH      (FW)
    ) u_inserter (
        .word    (acc_q),
        .chunk   (input_bits),
        .length  (len_c),
        .offset  (fill_q),
        .merged  (merged),
        .overflow(overflow)
    );

    // Next-state and output-register logic; the output register may be
    // drained and reloaded in the same cycle
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        out_bits_d  = out_bits_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q;

        out_free    = !out_valid_q || output_ready;
        input_ready = ready_en_q && (state_q == ACCUMULATE) && out_free;
        accepted    = input_valid && input_ready;

        if (out_valid_q && output_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ACCUMULATE: begin
                if (accepted) begin
                    if (complete) begin
                        out_bits_d  = merged;
                        out_len_d   = FW'(OW);
                        out_valid_d = 1'b1;
                        acc_d       = overflow;
                        fill_d      = new_fill;
                        if (input_flush && (new_fill != '0)) begin
                            state_d = FLUSH_PENDING;
                        end
                    end else if (input_flush && (new_fill != '0)) begin
                        out_bits_d  = partial_word(merged, new_fill);
                        out_len_d   = new_fill;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        fill_d      = '0;
                    end else begin
                        acc_d  = merged;
                        fill_d = new_fill;
                    end
                end
            end
            FLUSH_PENDING: begin
                if (out_free) begin
                    out_bits_d  = partial_word(acc_q, fill_q);
                    out_len_d   = fill_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    fill_d      = '0;
                    state_d     = ACCUMULATE;
                end
            end
            default: state_d = ACCUMULATE;
        endcase
    end

    // State and datapath registers; ready_en holds input_ready low until the
    // first clock after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCUMULATE;
            acc_q       <= '0;
            fill_q      <= '0;
            out_bits_q  <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_bits_q  <= out_bits_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign output_valid  = out_valid_q;
    assign output_bits   = out_bits_q;
    assign output_length = out_len_q;

endmodule

// File: tb/tb_bits_packer.sv
// Directed bench for bits_packer with default parameters.
// Build option: BITS_PACKER_MSB_FIRST_EN switches to the MSB-first vectors.
module tb_bits_packer;

    logic        clock;
    logic        reset_n;
    logic        input_valid;
    logic        input_ready;
    logic [7:0]  input_bits;
    logic [3:0]  input_length;
    logic        input_flush;
    logic        output_valid;
    logic        output_ready;
    logic [31:0] output_bits;
    logic [5:0]  output_length;

    int total = 0;
    int bad   = 0;

    bits_packer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_bits   (input_bits),
        .input_length (input_length),
        .input_flush  (input_flush),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_bits  (output_bits),
        .output_length(output_length)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one chunk from a falling edge, wait (bounded) for input_ready,
    // and return 1 time unit after the rising edge that transfers it
    task automatic send(input logic [7:0] b, input logic [3:0] l, input logic f);
        int n;
        @(negedge clock);
        input_valid  = 1'b1;
        input_bits   = b;
        input_length = l;
        input_flush  = f;
        n = 0;
        while (!input_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        total++;
        assert (n < 50) else begin
            bad++;
            $error("FAIL send_timeout observed=%0d expected=<50", n);
        end
        @(posedge clock);
        #1;
        input_valid = 1'b0;
        input_flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        input_valid  = 1'b0;
        input_bits   = '0;
        input_length = '0;
        input_flush  = 1'b0;
        output_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", output_valid, 0);
        check("rst_bits", output_bits, 0);
        check("rst_len", output_length, 0);
        check("rst_ready", input_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rel_ready_low", input_ready, 0);
        tick();
        check("rel_ready_high", input_ready, 1);

`ifdef BITS_PACKER_MSB_FIRST_EN
        send(8'h11, 4'd8, 1'b0);
        send(8'h22, 4'd8, 1'b0);
        send(8'h33, 4'd8, 1'b0);
        check("msb_pre_valid", output_valid, 0);
        send(8'h44, 4'd8, 1'b0);
        check("msb_w_valid", output_valid, 1);
        check("msb_w_bits", output_bits, 32'h11223344);
        check("msb_w_len", output_length, 32);
        send(8'h0A, 4'd4, 1'b1);
        check("msb_p_valid", output_valid, 1);
        check("msb_p_bits", output_bits, 32'hA0000000);
        check("msb_p_len", output_length, 4);
        tick();
        check("msb_p_drain", output_valid, 0);
`else
        // Four bytes make one LSB-first word, valid right after the 4th accept
        send(8'h11, 4'd8, 1'b0);
        send(8'h22, 4'd8, 1'b0);
        send(8'h33, 4'd8, 1'b0);
        check("t1_pre_valid", output_valid, 0);
        send(8'h44, 4'd8, 1'b0);
        check("t1_valid", output_valid, 1);
        check("t1_bits", output_bits, 32'h44332211);
        check("t1_len", output_length, 32);

        // Seven 5-bit chunks, length-0 flush emits the 3-bit residue
        for (int i = 0; i < 6; i++) send(8'h1F, 4'd5, 1'b0);
        check("t2_pre_valid", output_valid, 0);
        send(8'h1F, 4'd5, 1'b0);
        check("t2_w_valid", output_valid, 1);
        check("t2_w_bits", output_bits, 32'hFFFFFFFF);
        check("t2_w_len", output_length, 32);
        send(8'h00, 4'd0, 1'b1);
        check("t2_p_valid", output_valid, 1);
        check("t2_p_bits", output_bits, 32'h00000007);
        check("t2_p_len", output_length, 3);
        tick();
        check("t2_drain", output_valid, 0);

        // Backpressure: word held stable, input blocked
        output_ready = 1'b0;
        send(8'hDD, 4'd8, 1'b0);
        send(8'hCC, 4'd8, 1'b0);
        send(8'hBB, 4'd8, 1'b0);
        send(8'hAA, 4'd8, 1'b0);
        check("t3_valid", output_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_bits", output_bits, 32'hAABBCCDD);
            check("t3_hold_valid", output_valid, 1);
            check("t3_hold_ready", input_ready, 0);
        end
        output_ready = 1'b1;
        #1;
        check("t3_ready_rise", input_ready, 1);
        tick();
        check("t3_drain", output_valid, 0);

        // Fill 28, then 0xAB/8 with flush: full word then 4-bit residue
        send(8'h21, 4'd8, 1'b0);
        send(8'h43, 4'd8, 1'b0);
        send(8'h65, 4'd8, 1'b0);
        send(8'hF7, 4'd4, 1'b0);
        check("t4_pre_valid", output_valid, 0);
        output_ready = 1'b0;
        send(8'hAB, 4'd8, 1'b1);
        check("t4_w_valid", output_valid, 1);
        check("t4_w_bits", output_bits, 32'hB7654321);
        check("t4_w_len", output_length, 32);
        check("t4_fp_ready", input_ready, 0);
        tick();
        check("t4_fp_ready2", input_ready, 0);
        output_ready = 1'b1;
        #1;
        check("t4_fp_ready3", input_ready, 0);
        tick();
        check("t4_p_valid", output_valid, 1);
        check("t4_p_bits", output_bits, 32'h0000000A);
        check("t4_p_len", output_length, 4);
        check("t4_acc_ready", input_ready, 1);
        tick();
        check("t4_drain", output_valid, 0);

        // Clamp: length 15 treated as 8
        send(8'h5A, 4'd15, 1'b1);
        check("t5_clamp_bits", output_bits, 32'h0000005A);
        check("t5_clamp_len", output_length, 8);
        tick();

        // Reset with a word pending and residue in the accumulator
        output_ready = 1'b0;
        send(8'hFF, 4'd8, 1'b0);
        send(8'hFF, 4'd8, 1'b0);
        send(8'hFF, 4'd8, 1'b0);
        send(8'h0F, 4'd4, 1'b0);
        send(8'hCC, 4'd8, 1'b0);
        check("t6_w_valid", output_valid, 1);
        check("t6_w_bits", output_bits, 32'hCFFFFFFF);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", output_valid, 0);
        check("t6_rst_bits", output_bits, 0);
        check("t6_rst_len", output_length, 0);
        check("t6_rst_ready", input_ready, 0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        output_ready = 1'b1;
        #1;
        check("t6_rel_ready_low", input_ready, 0);
        tick();
        check("t6_rel_ready_high", input_ready, 1);
        send(8'h11, 4'd8, 1'b0);
        send(8'h22, 4'd8, 1'b0);
        send(8'h33, 4'd8, 1'b0);
        send(8'h44, 4'd8, 1'b0);
        check("t6_valid", output_valid, 1);
        check("t6_bits", output_bits, 32'h44332211);
        check("t6_len", output_length, 32);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
